led_chaser: RTL and testbench
=============================

# led_chaser

Parametrised running-light generator driving a bank of `LED_NUM` LEDs, and the successor to the fixed 4-LED, single-pattern chaser. It adds the following over that block:

- a configurable LED count and step period;
- four selectable patterns (rotate down, rotate up, ping-pong, bar fill);
- a pause control;
- a per-step strobe for downstream logic such as a buzzer or 7-segment step counter.

It sits in the board top level between the key/switch conditioning logic and the LED pins.

## Interface
Parameters:
- `LED_NUM`, default 4: number of LEDs. Legal range 2..32.
- `STEP_CYCLES`, default 10_000_000: `sys_clk` cycles per pattern step (0.2 s at 50 MHz). Legal range ≥ 2.
- `CNT_W`, default `$clog2(STEP_CYCLES)`: step counter width.

Ports:
- `sys_clk`, in, 1: system clock, 50 MHz.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: 1 = run the pattern; 0 = LEDs off and all state cleared.
- `pause`, in, 1: 1 = freeze the counter, position and LEDs.
- `mode`, in, 2: pattern select. See `led_pkg`.
- `led`, out, `LED_NUM`: LED drive, active-high. Bit `LED_NUM-1` is the leftmost LED.
- `step_pulse`, out, 1: one-cycle strobe on each position advance.

## Operation
- Reset (asynchronous): counter = 0, position = 0, direction = down, `mode_q` = `MODE_ROT_DN`, `led` = 0, `step_pulse` = 0.
- `enable` = 0 (synchronous): the same clearing as reset, except `mode_q` tracks `mode`. Has priority over `pause`.
- Counter: counts 0..`STEP_CYCLES-1` while `enable` = 1 and `pause` = 0, then wraps to 0. Terminal count = tick.
- Position advance on tick, per mode:
  - `MODE_ROT_DN` (00): one-hot, starts at the MSB and moves toward the LSB. After the LSB it wraps to the MSB. Period = `LED_NUM` steps.
  - `MODE_ROT_UP` (01): one-hot, starts at the LSB and moves toward the MSB. After the MSB it wraps to the LSB.
  - `MODE_PINGPONG` (10): one-hot, starts at the MSB and moves down.
    - At the LSB the direction flips to up; at the MSB it flips back to down. End LEDs are lit for one step only (no double dwell).
    - Period = 2·(`LED_NUM`−1) steps.
  - `MODE_FILL` (11): level k = 0..`LED_NUM`. `led` has the top k bits set, so level 0 = all off and level `LED_NUM` = all on. After level `LED_NUM` it wraps to 0. Period = `LED_NUM`+1 steps.
- Mode change: `mode` is registered into `mode_q` every cycle.
  - If `mode` ≠ `mode_q` while enabled, the counter, position and direction are cleared on that cycle. The new pattern restarts from its initial state.
  - No tick and no `step_pulse` occur on that cycle.
- `pause` = 1: counter, position, direction and `led` all hold. No tick. A mode change while paused still restarts the pattern, and the pattern stays frozen at its initial state.
- `step_pulse`: registered. High for exactly one cycle per position advance. Never high while `enable` = 0 or `pause` = 1.

## Timing
- `led` is registered and decoded from the current position. It reflects a position change one cycle after the change.
- `enable` rising at edge E: the initial pattern appears on `led` at edge E+1. The first advance is visible at E+`STEP_CYCLES`+1, with `step_pulse` high in the same cycle.
- Steady state: `led` changes exactly every `STEP_CYCLES` cycles. Pausing for P cycles delays every later step by P cycles.
- `enable` falling: `led` = 0 after the next edge.
- `rst_n` asserted mid-step: `led` = 0 immediately, with no clock required.

## Structure
- Package `led_pkg` holds:
  - `typedef enum logic [1:0] led_mode_t` with `MODE_ROT_DN`, `MODE_ROT_UP`, `MODE_PINGPONG`, `MODE_FILL`;
  - the shared 50 MHz `CLK_FREQ_HZ` constant.
- Sub-module `step_timer` contains the counter and tick generation.
  - Ports: `sys_clk`, `rst_n`, `run`, `clr`, `tick`.
  - It is reused by later blink and breathe blocks.
- The top level holds the position/direction state machine, the mode-change detection and the `led` decode.

## Test plan
All scenarios use `LED_NUM` = 4 and `STEP_CYCLES` = 4.

- Reset, then `enable` = 1 in `MODE_ROT_DN` → `led` = 1000, 0100, 0010, 0001, 1000, with each value held for 4 cycles. `step_pulse` is high on each change.
- `MODE_PINGPONG`, run 8 steps → 1000, 0100, 0010, 0001, 0010, 0100, 1000, 0100.
- `MODE_FILL`, run 6 steps → 0000, 1000, 1100, 1110, 1111, 0000.
- `MODE_ROT_UP` at 0100, `pause` = 1 for 10 cycles → `led` stays at 0100 with no `step_pulse`. After release, the next change comes 4 minus (already elapsed count) cycles later.
- Mode switch from `MODE_ROT_DN` to `MODE_FILL` mid-step → on the next cycle `led` = 0000 and the counter restarts. The next step (1000) occurs 4 cycles later, and no spurious pulse is seen.
- `rst_n` low mid-run with no clock edge → `led` = 0 immediately. `enable` dropped mid-run → `led` = 0000 after one edge. Re-enabling restarts at 1000 (for `MODE_ROT_DN`).

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern blocks.
package led_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;

  typedef enum logic [1:0] {
    MODE_ROT_DN   = 2'b00,
    MODE_ROT_UP   = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_FILL     = 2'b11
  } led_mode_t;

  // Ping-pong travel direction; "down" walks toward the LSB.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } led_dir_t;

endpackage

// File: rtl/step_timer.sv
// Free-running step counter: counts 0..STEP_CYCLES-1 while run is high and
// raises tick combinationally on the terminal count. clr wins over run.
module step_timer #(
  parameter int STEP_CYCLES = 10_000_000,
  parameter int CNT_W       = $clog2(STEP_CYCLES)
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && !clr && (cnt == CNT_LAST);

  // Step counter: cleared on clr, wraps to zero on terminal count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Running-light generator: four patterns, pause, per-step strobe.
// led is decoded from the position one cycle after it changes; step_pulse
// is delayed by the same cycle so it coincides with the visible LED change.
module led_chaser
  import led_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 10_000_000,
  parameter int CNT_W       = $clog2(STEP_CYCLES)
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pause,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse
);

  // Position must reach LED_NUM for the fill pattern (all LEDs on).
  localparam int POS_W = $clog2(LED_NUM + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_NUM - 1);
  localparam logic [POS_W-1:0] POS_FULL = POS_W'(LED_NUM);

  led_mode_t        mode_q;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_next;
  led_dir_t         dir;
  led_dir_t         dir_next;
  logic             tick;
  logic             mode_chg;
  logic             run;
  logic             clr;
  logic             step_p0;

  assign mode_chg = enable && (led_mode_t'(mode) != mode_q);
  assign run      = enable && !pause && !mode_chg;
  assign clr      = !enable || mode_chg;

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_step_timer (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .run     (run),
    .clr     (clr),
    .tick    (tick)
  );

  // Position is an offset from the pattern's start: rotate/ping-pong light
  // bit LED_NUM-1-pos (or bit pos for rotate-up); fill lights the top pos bits.
  function automatic logic [LED_NUM-1:0] decode(input logic [POS_W-1:0] p,
                                                input led_mode_t        m);
    logic [LED_NUM-1:0] v;
    v = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      case (m)
        MODE_ROT_UP: v[i] = (int'(p) == i);
        MODE_FILL:   v[i] = (i >= LED_NUM - int'(p));
        default:     v[i] = (int'(p) == LED_NUM - 1 - i);
      endcase
    end
    return v;
  endfunction

  // Next position/direction on each tick; holds otherwise.
  always_comb begin
    pos_next = pos;
    dir_next = dir;
    if (tick) begin
      case (mode_q)
        MODE_ROT_DN, MODE_ROT_UP: begin
          pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
        end
        MODE_PINGPONG: begin
          if (dir == DIR_DOWN) begin
            pos_next = pos + 1'b1;
            if (pos_next == POS_LAST) dir_next = DIR_UP;
          end else begin
            pos_next = pos - 1'b1;
            if (pos_next == '0) dir_next = DIR_DOWN;
          end
        end
        MODE_FILL: begin
          pos_next = (pos == POS_FULL) ? '0 : pos + 1'b1;
        end
        default: begin
          pos_next = '0;
        end
      endcase
    end
  end

  // State and output registers: disable clears, a mode change restarts the
  // pattern without a step, pause freezes everything but mode tracking.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_ROT_DN;
      pos        <= '0;
      dir        <= DIR_DOWN;
      led        <= '0;
      step_p0    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      mode_q <= led_mode_t'(mode);
      if (!enable) begin
        pos        <= '0;
        dir        <= DIR_DOWN;
        led        <= '0;
        step_p0    <= 1'b0;
        step_pulse <= 1'b0;
      end else if (mode_chg) begin
        pos        <= '0;
        dir        <= DIR_DOWN;
        step_p0    <= 1'b0;
        step_pulse <= 1'b0;
      end else if (pause) begin
        step_pulse <= 1'b0;
      end else begin
        pos        <= pos_next;
        dir        <= dir_next;
        led        <= decode(pos, mode_q);
        step_p0    <= tick;
        step_pulse <= step_p0;
      end
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser with LED_NUM=4, STEP_CYCLES=4.
module tb_led_chaser;

  localparam int N = 4;
  localparam int S = 4;

  logic         sys_clk;
  logic         rst_n;
  logic         enable;
  logic         pause;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic         step_pulse;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_seq [0:7];

  led_chaser #(
    .LED_NUM     (N),
    .STEP_CYCLES (S)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pause      (pause),
    .mode       (mode),
    .led        (led),
    .step_pulse (step_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // LED image for step index k since the pattern (re)started.
  function automatic logic [3:0] pattern(input logic [1:0] m, input int k);
    logic [3:0] v;
    int p;
    v = '0;
    case (m)
      2'd0: v[N-1-(k % N)] = 1'b1;
      2'd1: v[k % N] = 1'b1;
      2'd2: begin
        p = k % (2 * (N - 1));
        v[(p < N - 1) ? (N - 1 - p) : (p - (N - 1))] = 1'b1;
      end
      default: begin
        p = k % (N + 1);
        v = 4'(((1 << p) - 1) << (N - p));
      end
    endcase
    return v;
  endfunction

  // Model: act_m counts enabled, unpaused cycles since the last restart;
  // the LED shows step floor(act_m/S) one edge later, with a strobe at each
  // multiple of S after the first.
  int         act_m;
  logic [1:0] mq_m;
  logic [3:0] led_m;
  logic       sp_m;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_m <= 0; mq_m <= 2'd0; led_m <= '0; sp_m <= 1'b0;
    end else if (!enable) begin
      act_m <= 0; mq_m <= mode; led_m <= '0; sp_m <= 1'b0;
    end else if (mode != mq_m) begin
      act_m <= 0; mq_m <= mode; sp_m <= 1'b0;
    end else if (pause) begin
      sp_m <= 1'b0;
    end else begin
      act_m <= act_m + 1;
      led_m <= pattern(mq_m, act_m / S);
      sp_m  <= (act_m > 0) && (act_m % S == 0);
    end
  end

  always @(negedge sys_clk) begin
    chk("model_led", led, led_m);
    chk("model_pulse", step_pulse, sp_m);
  end

  // Wait for each of n strobes; check LED value and spacing.
  task automatic collect(input string name, input int n, input int first_gap);
    int cyc;
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = (i == 0) ? first_gap : S;
      cyc = 0;
      do begin
        @(negedge sys_clk);
        cyc++;
      end while (!step_pulse && cyc < 3 * S);
      chk({name, "_pulse"}, step_pulse, 1);
      chk({name, "_led"}, led, exp_seq[i]);
      chk({name, "_gap"}, cyc, gap);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; pause = 1'b0; mode = 2'd0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("reset_led", led, 4'b0000);
    chk("reset_pulse", step_pulse, 0);
    #2 rst_n = 1'b1;

    // Rotate down from enable, including wrap LSB -> MSB.
    @(posedge sys_clk); #1 enable = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("rotdn_init", led, 4'b1000);
    exp_seq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0};
    collect("rotdn", 4, S);

    // Ping-pong with single dwell at both ends.
    @(posedge sys_clk); #1 mode = 2'd2;
    @(posedge sys_clk); @(posedge sys_clk); @(negedge sys_clk);
    chk("pp_init", led, 4'b1000);
    exp_seq = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0};
    collect("pp", 7, S);

    // Rotate down, then switch to fill mid-step.
    @(posedge sys_clk); #1 mode = 2'd0;
    @(posedge sys_clk); @(posedge sys_clk); @(negedge sys_clk);
    chk("rotdn2_init", led, 4'b1000);
    repeat (2) @(posedge sys_clk);
    #1 mode = 2'd3;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("fill_chg_nopulse", step_pulse, 0);
    @(posedge sys_clk); @(negedge sys_clk);
    chk("fill_init", led, 4'b0000);
    exp_seq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b0, 4'b0, 4'b0};
    collect("fill", 5, S);

    // Rotate up to 0100, then pause for 10 cycles.
    @(posedge sys_clk); #1 mode = 2'd1;
    @(posedge sys_clk); @(posedge sys_clk); @(negedge sys_clk);
    chk("rotup_init", led, 4'b0001);
    exp_seq = '{4'b0010, 4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    collect("rotup", 2, S);
    @(posedge sys_clk); #1 pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("pause_led", led, 4'b0100);
      chk("pause_pulse", step_pulse, 0);
    end
    @(posedge sys_clk); #1 pause = 1'b0;
    exp_seq = '{4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    collect("resume", 2, 4);

    // Asynchronous reset mid-run, no clock edge needed.
    @(posedge sys_clk); #1 mode = 2'd0;
    repeat (6) @(posedge sys_clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 4'b0000);
    chk("async_rst_pulse", step_pulse, 0);
    @(posedge sys_clk); #2 rst_n = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("post_rst_init", led, 4'b1000);

    // Enable drop and re-enable.
    repeat (5) @(posedge sys_clk);
    #1 enable = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("disable_led", led, 4'b0000);
    chk("disable_pulse", step_pulse, 0);
    @(posedge sys_clk); #1 enable = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("reen_init", led, 4'b1000);
    exp_seq = '{4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    collect("reen", 1, S);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
